// File: rtl/pe_sched.sv
// -----------------------------------------------------------------------------
// pe_sched
//   Sequencer for one multiply-accumulate PE running 3x3 (9-tap) convolution
//   windows. It holds the filter weights, pairs each incoming window pixel with
//   its weight, clears the PE accumulator on tap 0, waits out the PE pipeline
//   and hands one result per window to a downstream consumer.
//
// Ports
//   clk, rst             : clock (rising edge) and async active-high reset
//   cfg_we/addr/data     : weight write port, honoured only while idle
//   start, num_win       : job launch pulse and number of windows in the job
//   px_valid/data/ready  : pixel stream in, tap order 0..TAPS-1 per window
//   pe_in, pe_filter     : registered operand pair to the PE
//   pe_en, pe_clr        : operand-valid and accumulator clear (on tap 0)
//   pe_out               : PE accumulator result
//   res_valid/data/ready : one result per window out
//   busy, done           : job active / one-cycle job-complete pulse
//
// State  | Meaning
// -------+------------------------------------------------------------------
// IDLE   | weights writable, waiting for start
// RUN    | accepting pixels, issuing one MAC per pixel handshake
// WAIT   | draining the PE pipeline (PE_LAT cycles, down-counter)
// OUT    | result offered downstream until accepted
// -----------------------------------------------------------------------------
module pe_sched #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 9,
    parameter int PE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [7:0]        num_win,
    input  logic              px_valid,
    input  logic [DATA_W-1:0] px_data,
    output logic              px_ready,
    output logic [DATA_W-1:0] pe_in,
    output logic [DATA_W-1:0] pe_filter,
    output logic              pe_en,
    output logic              pe_clr,
    input  logic [DATA_W-1:0] pe_out,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] TAP_CNT  = 4'(TAPS);
    localparam logic [3:0] TAP_LAST = 4'(TAPS - 1);
    localparam logic [3:0] LAT_INIT = 4'(PE_LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t            state_q,     state_d;
    logic [3:0]        tap_q,       tap_d;
    logic [3:0]        lat_cnt_q,   lat_cnt_d;
    logic [7:0]        win_left_q,  win_left_d;
    logic [DATA_W-1:0] w_q [TAPS];
    logic [DATA_W-1:0] w_d [TAPS];

    logic [DATA_W-1:0] pe_in_q,     pe_in_d;
    logic [DATA_W-1:0] pe_filter_q, pe_filter_d;
    logic              pe_en_q,     pe_en_d;
    logic              pe_clr_q,    pe_clr_d;
    logic              px_ready_q,  px_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        lat_cnt_d   = lat_cnt_q;
        win_left_d  = win_left_q;
        w_d         = w_q;
        pe_in_d     = pe_in_q;
        pe_filter_d = pe_filter_q;
        pe_en_d     = 1'b0;
        pe_clr_d    = 1'b0;
        res_data_d  = res_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The write is applied before start is evaluated, so a job
                // launched in the same cycle already sees the new weight.
                if (cfg_we && (cfg_addr < TAP_CNT)) begin
                    w_d[cfg_addr] = cfg_data;
                end
                if (start) begin
                    win_left_d = num_win;
                    tap_d      = '0;
                    if (num_win == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (px_valid && px_ready_q) begin
                    pe_in_d     = px_data;
                    pe_filter_d = w_q[tap_q];
                    pe_en_d     = 1'b1;
                    pe_clr_d    = (tap_q == 4'd0);
                    if (tap_q == TAP_LAST) begin
                        tap_d     = '0;
                        lat_cnt_d = LAT_INIT;
                        state_d   = ST_WAIT;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
            end

            ST_WAIT: begin
                // Terminal count at 1: the last WAIT cycle samples pe_out,
                // which by then holds the final window sum.
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    res_data_d = pe_out;
                    state_d    = ST_OUT;
                end
            end

            ST_OUT: begin
                if (res_ready) begin
                    win_left_d = win_left_q - 8'd1;
                    if (win_left_q == 8'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Handshake flags are decoded from the next state so they are plain
        // flops; res_ready never reaches px_ready combinationally.
        px_ready_d  = (state_d == ST_RUN);
        res_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            lat_cnt_q   <= '0;
            win_left_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                w_q[i] <= '0;
            end
            pe_in_q     <= '0;
            pe_filter_q <= '0;
            pe_en_q     <= 1'b0;
            pe_clr_q    <= 1'b0;
            px_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            lat_cnt_q   <= lat_cnt_d;
            win_left_q  <= win_left_d;
            w_q         <= w_d;
            pe_in_q     <= pe_in_d;
            pe_filter_q <= pe_filter_d;
            pe_en_q     <= pe_en_d;
            pe_clr_q    <= pe_clr_d;
            px_ready_q  <= px_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign px_ready  = px_ready_q;
    assign pe_in     = pe_in_q;
    assign pe_filter = pe_filter_q;
    assign pe_en     = pe_en_q;
    assign pe_clr    = pe_clr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
